// File: rtl/edge_gen.sv
// Falling-edge pulse generator: programmable low time and minimum trailing high
// time, with a one-deep request slot, overrun strobe and synchronous abort.
module edge_gen #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] low_len,
  input  logic [CW-1:0] gap_len,
  input  logic          abort,
  output logic          out,
  output logic          busy,
  output logic          pend,
  output logic          done,
  output logic          overrun
);

  typedef enum logic [1:0] {IDLE, LOW, GAP} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] gap_q;
  logic [CW-1:0] pl_q;
  logic [CW-1:0] pg_q;
  logic          out_q;
  logic          busy_q;
  logic          pend_q;
  logic          done_q;
  logic          ovr_q;

  logic [CW-1:0] l_eff;
  logic [CW-1:0] g_eff;
  logic          gap_exit;

  always_comb begin
    l_eff    = (low_len == '0) ? CW'(1) : low_len;
    g_eff    = (gap_len == '0) ? CW'(1) : gap_len;
    gap_exit = (state_q == GAP) && (cnt_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      pl_q    <= '0;
      pg_q    <= '0;
      out_q   <= 1'b1;
      busy_q  <= 1'b0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        out_q   <= 1'b1;
        busy_q  <= 1'b0;
        pend_q  <= 1'b0;
      end else begin
        // Busy-time start: queue or drop. A start at GAP exit with an empty
        // slot is taken as a fresh IDLE start in the case below instead.
        if (start && (state_q != IDLE) && !(gap_exit && !pend_q)) begin
          if (pend_q) begin
            ovr_q <= 1'b1;
          end else begin
            pend_q <= 1'b1;
            pl_q   <= l_eff;
            pg_q   <= g_eff;
          end
        end
        case (state_q)
          IDLE: begin
            if (start) begin
              state_q <= LOW;
              out_q   <= 1'b0;
              busy_q  <= 1'b1;
              cnt_q   <= l_eff - CW'(1);
              gap_q   <= g_eff;
            end
          end
          LOW: begin
            if (cnt_q == '0) begin
              state_q <= GAP;
              out_q   <= 1'b1;
              cnt_q   <= gap_q - CW'(1);
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          GAP: begin
            if (cnt_q == '0) begin
              done_q <= 1'b1;
              if (pend_q) begin
                state_q <= LOW;
                out_q   <= 1'b0;
                cnt_q   <= pl_q - CW'(1);
                gap_q   <= pg_q;
                pend_q  <= 1'b0;
              end else if (start) begin
                state_q <= LOW;
                out_q   <= 1'b0;
                cnt_q   <= l_eff - CW'(1);
                gap_q   <= g_eff;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                cnt_q   <= '0;
              end
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            out_q   <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign out     = out_q;
  assign busy    = busy_q;
  assign pend    = pend_q;
  assign done    = done_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_edge_gen.sv
// Bench for edge_gen: hand-computed vector table, corner sequences, and random
// traffic checked against a timestamp-based pulse schedule model.
module tb_edge_gen;

  localparam int unsigned CW = 8;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] low_len;
  logic [CW-1:0] gap_len;
  logic          abort;
  logic          out;
  logic          busy;
  logic          pend;
  logic          done;
  logic          overrun;

  edge_gen #(.CW(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .low_len (low_len),
    .gap_len (gap_len),
    .abort   (abort),
    .out     (out),
    .busy    (busy),
    .pend    (pend),
    .done    (done),
    .overrun (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a pulse is a falling time plus its effective lengths; the line is
  // low for L cycles from the fall and the pulse ends L+G cycles after it.
  int m_n;
  bit m_busy;
  int m_fall, m_L, m_G;
  int qL[$];
  int qG[$];
  bit m_done, m_ovr;

  function automatic int eff(input int x);
    return (x == 0) ? 1 : x;
  endfunction

  task automatic model_reset();
    m_busy = 0;
    m_done = 0;
    m_ovr  = 0;
    qL.delete();
    qG.delete();
  endtask

  task automatic model_step(input bit s, input int L, input int G, input bit a);
    bit had_pend;
    bit taken;
    bit fin;
    m_done   = 0;
    m_ovr    = 0;
    had_pend = (qL.size() != 0);
    taken    = 0;
    if (a) begin
      m_busy = 0;
      qL.delete();
      qG.delete();
    end else begin
      fin = m_busy && (m_n == m_fall + m_L + m_G);
      if (fin) begin
        m_done = 1;
        if (had_pend) begin
          m_fall = m_n;
          m_L    = qL.pop_front();
          m_G    = qG.pop_front();
        end else if (s) begin
          m_fall = m_n; m_L = eff(L); m_G = eff(G); taken = 1;
        end else begin
          m_busy = 0;
        end
      end else if (!m_busy && s) begin
        m_busy = 1; m_fall = m_n; m_L = eff(L); m_G = eff(G); taken = 1;
      end
      if (s && !taken) begin
        if (had_pend) m_ovr = 1;
        else begin
          qL.push_back(eff(L));
          qG.push_back(eff(G));
        end
      end
    end
  endtask

  function automatic bit model_out();
    return !(m_busy && (m_n - m_fall) < m_L);
  endfunction

  task automatic cycle(input bit s, input int L, input int G, input bit a);
    start   = s;
    low_len = CW'(L);
    gap_len = CW'(G);
    abort   = a;
    @(posedge clk);
    m_n++;
    model_step(s, L, G, a);
    #1;
    chk("out",     out,     model_out());
    chk("busy",    busy,    m_busy);
    chk("pend",    pend,    qL.size() != 0);
    chk("done",    done,    m_done);
    chk("overrun", overrun, m_ovr);
  endtask

  typedef struct {
    bit s; int l; int g; bit a;
    bit eo; bit eb; bit ep; bit ed; bit ev;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit s, input int l, input int g, input bit a,
                     input bit eo, input bit eb, input bit ep, input bit ed, input bit ev);
    vec_t v;
    v.s = s; v.l = l; v.g = g; v.a = a;
    v.eo = eo; v.eb = eb; v.ep = ep; v.ed = ed; v.ev = ev;
    tbl.push_back(v);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; low_len = '0; gap_len = '0;
    m_n = 0;
    model_reset();
    @(posedge clk); #1;
    chk("rst_out",  out,     1'b1);
    chk("rst_busy", busy,    1'b0);
    chk("rst_pend", pend,    1'b0);
    chk("rst_done", done,    1'b0);
    chk("rst_ovr",  overrun, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // single pulse L=3 G=2 started at edge 5
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 3, 2, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    // zero lengths
    add(1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    // queued request: second fall 5 cycles after the first
    add(1, 3, 2, 0, 0, 1, 0, 0, 0);
    add(1, 2, 1, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    // overrun: third start dropped, pending keeps L=2 G=2
    add(1, 3, 1, 0, 0, 1, 0, 0, 0);
    add(1, 2, 2, 0, 0, 1, 1, 0, 0);
    add(1, 4, 4, 0, 0, 1, 1, 0, 1);
    add(0, 0, 0, 0, 1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    // abort with pending request and simultaneous start
    add(1, 4, 2, 0, 0, 1, 0, 0, 0);
    add(1, 2, 1, 0, 0, 1, 1, 0, 0);
    add(1, 3, 3, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 0, 0, 0, 1, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      cycle(tbl[i].s, tbl[i].l, tbl[i].g, tbl[i].a);
      chk("tbl_out",  out,     tbl[i].eo);
      chk("tbl_busy", busy,    tbl[i].eb);
      chk("tbl_pend", pend,    tbl[i].ep);
      chk("tbl_done", done,    tbl[i].ed);
      chk("tbl_ovr",  overrun, tbl[i].ev);
    end

    // asynchronous reset in the middle of LOW with a request pending
    cycle(1, 5, 1, 0);
    cycle(1, 2, 2, 0);
    cycle(0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out",  out,     1'b1);
    chk("arst_busy", busy,    1'b0);
    chk("arst_pend", pend,    1'b0);
    chk("arst_done", done,    1'b0);
    chk("arst_ovr",  overrun, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 2, 1, 0);
    chk("first_start_out", out, 1'b0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);

    // maximum length: no counter wrap; length inputs wiggle without start
    cycle(1, 255, 0, 0);
    for (int i = 0; i < 262; i++)
      cycle(0, $urandom_range(0, 255), $urandom_range(0, 255), 0);

    // random traffic
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 99) < 30, $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 99) < 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/edge_gen.md
EDGE_GEN -- requirements
Module: edge_gen

Interface
REQ-001 Parameter CW, default 8: width of the low-time and gap-time length fields.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request for one falling-edge pulse; sampled on the rising clk edge.
REQ-005 low_len  input  CW  pulse low time in cycles; sampled with start.
REQ-006 gap_len  input  CW  minimum high time after the pulse, in cycles; sampled with start.
REQ-007 abort  input  1  synchronous cancel of the current and pending pulses.
REQ-008 out  output  1  generated line; idles high; each pulse is a falling edge followed by a rising edge.
REQ-009 busy  output  1  high whenever the FSM is not IDLE.
REQ-010 pend  output  1  high while the one-deep pending request slot holds a request.
REQ-011 done  output  1  one-cycle strobe at completion of each pulse, including its gap.
REQ-012 overrun  output  1  one-cycle strobe when a start is dropped.

Function
REQ-013 The FSM SHALL have the states IDLE, LOW and GAP.
- out = 1 in IDLE and GAP.
- out = 0 in LOW.
- All outputs are registered.
REQ-014 Start in IDLE: a start sampled at edge t SHALL latch low_len and gap_len, enter LOW at edge t, and drive out = 0 from edge t.
REQ-015 Effective lengths: effective length = max(len, 1); a length of 0 SHALL be treated as 1, so that out never glitches and a rising edge is always followed by at least one high cycle.
REQ-016 LOW timing: LOW SHALL last exactly L cycles.
- The down-counter is loaded with L-1.
- LOW exits to GAP when the count is 0.
REQ-017 GAP timing: GAP SHALL last exactly G cycles.
- At GAP exit, done = 1 for one cycle, registered together with the state change.
REQ-018 Exit from GAP:
- pend = 0: the FSM goes to IDLE.
- pend = 1: the FSM goes directly to LOW using the pending lengths, and pend clears on that edge.
REQ-019 Start while busy with pend = 0: the request and its lengths SHALL be stored, and pend = 1 from the next cycle.
REQ-020 Start while busy with pend = 1: the start SHALL be dropped, overrun pulses for one cycle, and the stored request is unchanged.
REQ-021 Start on the same edge as GAP exit with pend = 0:
- The request is handled as an IDLE start.
- The FSM goes straight to LOW.
- done still pulses.
REQ-022 Abort has the highest priority. On an edge with abort = 1:
- FSM goes to IDLE and out = 1.
- pend clears.
- The counter clears.
- No done is generated.
- Any start sampled on the same edge is ignored, and no overrun is generated.
REQ-023 Back-to-back pulses: the interval between consecutive falling edges on out SHALL be exactly L+G cycles when a request is pending.
REQ-024 The counter SHALL be CW bits wide and SHALL never wrap. Maximum length is 2^CW-1 cycles.
REQ-025 Input sampling: changes on low_len or gap_len while no start is asserted SHALL have no effect on a pulse in progress.

Reset
REQ-026 While rst_n = 0, the block SHALL hold:
- FSM = IDLE.
- out = 1.
- busy = 0, pend = 0, done = 0, overrun = 0.
- counter = 0.
REQ-027 Reset assertion mid-pulse SHALL immediately force out = 1 and discard all requests.
REQ-028 After reset deassertion, the first start SHALL be accepted on the first rising clk edge with rst_n = 1.

Verification
REQ-029 Single pulse:
- Stimulus: start at edge 5, L = 3, G = 2.
- Required response: out = 0 for edges 5-7 and high from edge 8; done in the cycle after edge 10; busy low after edge 10.
REQ-030 Zero lengths:
- Stimulus: L = 0, G = 0.
- Required response: out low for exactly 1 cycle, high for at least 1 cycle; done asserted once.
REQ-031 Queued request:
- Stimulus: a second start (L = 2, G = 1) during the first pulse's LOW phase.
- Required response: pend = 1; second falling edge exactly L1+G1 cycles after the first; pend clears when the second pulse starts; two done pulses.
REQ-032 Overrun:
- Stimulus: three starts during one pulse.
- Required response: one overrun pulse; only two pulses generated; the pending lengths are those of the second start.
REQ-033 Abort:
- Stimulus: abort on the second LOW cycle with pend = 1, plus a simultaneous start.
- Required response: out = 1 on the next edge; busy = 0; pend = 0; no done; no further pulses.
REQ-034 Asynchronous reset:
- Stimulus: rst_n = 0 asserted mid-cycle during LOW.
- Required response: out = 1 without waiting for a clk edge; all strobes 0; normal operation on the first start after release.
